booth_controlpath: RTL and testbench

- FSM controller that sequences the radix-4 Booth multiplier DataPath (registroM, ADDER, shifterQ, shifterLO, registroX).
- On START it loads the operands and runs tamano/2 iterations. Each iteration decodes the 3-bit Booth window, issues 0, 1 or 2 ADDER cycles, then performs a 2-bit arithmetic shift of HI/LO/X.
- Pulses END when S is valid.
- Sits beside DataPath in the top level and drives every DataPath control input.

---
 rtl/booth_pkg.sv | 52 +++++
 rtl/booth_controlpath_if.sv | 58 +++++
 rtl/iter_counter.sv | 37 +++
 rtl/booth_controlpath.sv | 124 ++++++++++++
 tb/tb_booth_controlpath.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier controller.
package booth_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    ADD1,
    ADD2,
    SHIFT,
    DONE
  } state_t;

  // ADDER operation codes driven on ACCU; 2'b11 is never issued.
  localparam logic [1:0] ACCU_PASS = 2'b00;
  localparam logic [1:0] ACCU_ADD  = 2'b01;
  localparam logic [1:0] ACCU_SUB  = 2'b10;

  // Operation selected by one radix-4 Booth window.
  typedef enum logic [2:0] {
    NONE,
    PM,
    P2M,
    MM,
    M2M
  } booth_op_t;

  // Map the {q(i+1), q(i), q(i-1)} window onto a Booth operation.
  function automatic booth_op_t booth_decode(input logic [2:0] control);
    booth_op_t op;
    case (control)
      3'b001, 3'b010: op = PM;
      3'b011:         op = P2M;
      3'b100:         op = M2M;
      3'b101, 3'b110: op = MM;
      default:        op = NONE;
    endcase
    return op;
  endfunction

  // Double-magnitude ops take two ADDER cycles.
  function automatic logic is_double(input booth_op_t op);
    return (op == P2M) || (op == M2M);
  endfunction

  // Negative ops subtract M from HI.
  function automatic logic is_sub(input booth_op_t op);
    return (op == MM) || (op == M2M);
  endfunction

endpackage

// File: rtl/booth_controlpath_if.sv
// Control bundle between the Booth controller and its DataPath.
interface booth_controlpath_if;

  logic       START;
  logic [2:0] control;
  logic [1:0] ACCU;
  logic       enableM;
  logic       enableLO;
  logic       CARGA_LO;
  logic       enableSHI;
  logic       CARGA_SHI;
  logic       enableX;
  logic       CARGA_X;
  logic       clearX;
  logic       clearSHI;
  logic       clearLO;
  logic       BUSY;
  logic       END;

  // Controller side: receives the request and Booth window, drives every DataPath control.
  modport master (
    input  START,
    input  control,
    output ACCU,
    output enableM,
    output enableLO,
    output CARGA_LO,
    output enableSHI,
    output CARGA_SHI,
    output enableX,
    output CARGA_X,
    output clearX,
    output clearSHI,
    output clearLO,
    output BUSY,
    output END
  );

  // DataPath / requester side.
  modport slave (
    output START,
    output control,
    input  ACCU,
    input  enableM,
    input  enableLO,
    input  CARGA_LO,
    input  enableSHI,
    input  CARGA_SHI,
    input  enableX,
    input  CARGA_X,
    input  clearX,
    input  clearSHI,
    input  clearLO,
    input  BUSY,
    input  END
  );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter with synchronous clear, enable and terminal-count flag.
module iter_counter #(
  parameter int unsigned num_iter = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned Width = (num_iter > 1) ? $clog2(num_iter) : 1;

  logic [Width-1:0] count_q, count_d;

  // Clear wins over enable; the controller never enables past the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == Width'(num_iter - 1));

endmodule

// File: rtl/booth_controlpath.sv
// Radix-4 Booth multiplier controller: loads operands, then for each of tamano/2
// iterations decodes the Booth window, issues 0..2 ADDER cycles and a 2-bit shift.
// tamano must be even and at least 4.
module booth_controlpath
  import booth_pkg::*;
#(
  parameter int unsigned tamano = 8
) (
  input logic                 CLOCK,
  input logic                 RESET,
  booth_controlpath_if.master bus
);

  localparam int unsigned Iters = tamano / 2;

  state_t    state_q, state_d;
  booth_op_t op_q, op_d;
  logic      cnt_clear;
  logic      cnt_enable;
  logic      cnt_last;

  // Counter is zeroed in LOAD and advanced on every non-final SHIFT.
  assign cnt_clear  = (state_q == LOAD);
  assign cnt_enable = (state_q == SHIFT) && !cnt_last;

  iter_counter #(
    .num_iter(Iters)
  ) u_iter_counter (
    .clk   (CLOCK),
    .rst   (RESET),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .last  (cnt_last)
  );

  // State and latched Booth op.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state; the op is captured only in EVAL so it stays stable through SHIFT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = EVAL;
      end
      EVAL: begin
        op_d    = booth_decode(bus.control);
        state_d = (op_d == NONE) ? SHIFT : ADD1;
      end
      ADD1: begin
        state_d = is_double(op_q) ? ADD2 : SHIFT;
      end
      ADD2: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        state_d = cnt_last ? DONE : EVAL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode from state and latched op.
  always_comb begin
    bus.ACCU      = ACCU_PASS;
    bus.enableM   = 1'b0;
    bus.enableLO  = 1'b0;
    bus.CARGA_LO  = 1'b0;
    bus.enableSHI = 1'b0;
    bus.CARGA_SHI = 1'b0;
    bus.enableX   = 1'b0;
    bus.CARGA_X   = 1'b0;
    bus.clearX    = 1'b0;
    bus.clearSHI  = 1'b0;
    bus.clearLO   = 1'b0;
    bus.BUSY      = (state_q != IDLE);
    bus.END       = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.enableM  = 1'b1;
        bus.enableLO = 1'b1;
        bus.CARGA_LO = 1'b1;
        bus.clearSHI = 1'b1;
        bus.clearX   = 1'b1;
      end
      // A +-2M op is two back-to-back +-M accumulations.
      ADD1, ADD2: begin
        bus.ACCU      = is_sub(op_q) ? ACCU_SUB : ACCU_ADD;
        bus.enableSHI = 1'b1;
        bus.CARGA_SHI = 1'b1;
      end
      SHIFT: begin
        bus.enableSHI = 1'b1;
        bus.enableLO  = 1'b1;
        bus.enableX   = 1'b1;
      end
      DONE: begin
        bus.END = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controlpath.sv
// Bench for booth_controlpath: a behavioural DataPath closes the loop, a scoreboard
// queue holds expected per-operation results, and a monitor checks them at END.
module tb_booth_controlpath;

  typedef struct {
    int          lat;
    int          nadd;
    logic [15:0] seq;
    logic        chk_s;
    logic [15:0] s;
    int          gap;
  } exp_t;

  logic CLOCK;
  logic RESET;

  booth_controlpath_if bus ();

  booth_controlpath #(
    .tamano(8)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  int   total;
  int   bad;
  int   end_cnt;
  int   n_exp;
  int   cyc_g;
  int   last_end;
  exp_t exp_q[$];

  logic       use_dp;
  logic [2:0] forced_ctrl;
  logic [7:0] dp_a, dp_b;

  // Behavioural DataPath with a widened HI so +-M steps never overflow.
  logic signed [11:0] hi;
  logic [7:0]         lo, m;
  logic               x;
  logic [15:0]        s;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc_g <= cyc_g + 1;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hi <= '0;
      lo <= '0;
      m  <= '0;
      x  <= 1'b0;
    end else begin
      if (bus.enableM) m <= dp_b;
      if (bus.clearSHI) hi <= '0;
      else if (bus.enableSHI && bus.CARGA_SHI) begin
        if (bus.ACCU == 2'b01) hi <= hi + {{4{m[7]}}, m};
        else if (bus.ACCU == 2'b10) hi <= hi - {{4{m[7]}}, m};
      end else if (bus.enableSHI) hi <= hi >>> 2;
      if (bus.enableLO && bus.CARGA_LO) lo <= dp_a;
      else if (bus.enableLO) lo <= {hi[1:0], lo[7:2]};
      if (bus.clearX) x <= 1'b0;
      else if (bus.enableX) x <= lo[1];
    end
  end

  assign s           = {hi[7:0], lo};
  assign bus.control = use_dp ? {lo[1], lo[0], x} : forced_ctrl;

  function automatic logic [13:0] outs();
    return {bus.ACCU, bus.enableM, bus.enableLO, bus.CARGA_LO, bus.enableSHI, bus.CARGA_SHI,
            bus.enableX, bus.CARGA_X, bus.clearX, bus.clearSHI, bus.clearLO, bus.BUSY, bus.END};
  endfunction

  function automatic exp_t mk(input int lat, input int nadd, input int seq, input logic chk,
                              input int sv, input int gap);
    exp_t e;
    e.lat   = lat;
    e.nadd  = nadd;
    e.seq   = 16'(seq);
    e.chk_s = chk;
    e.s     = 16'(sv);
    e.gap   = gap;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wait_end(input int target);
    int t;
    t = 0;
    while (end_cnt < target && t < 200) begin
      @(negedge CLOCK);
      #1;
      t++;
    end
    if (end_cnt < target) check("end_timeout", end_cnt, target);
  endtask

  task automatic run_op(input logic dp, input logic [2:0] fc, input logic [7:0] a,
                        input logic [7:0] b, input exp_t e);
    @(negedge CLOCK);
    use_dp      = dp;
    forced_ctrl = fc;
    dp_a        = a;
    dp_b        = b;
    exp_q.push_back(e);
    n_exp++;
    bus.START = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    wait_end(n_exp);
  endtask

  // Monitor: tracks each operation from LOAD and scores it at END.
  initial begin
    exp_t        e;
    int          cyc;
    int          nadd;
    logic [15:0] seq;
    logic        active;
    logic        viol;
    active   = 1'b0;
    viol     = 1'b0;
    cyc      = 0;
    nadd     = 0;
    seq      = '0;
    last_end = 0;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        active = 1'b0;
        continue;
      end
      if (bus.enableM) begin
        active = 1'b1;
        cyc    = 1;
        nadd   = 0;
        seq    = '0;
        viol   = 1'b0;
      end else if (active) begin
        cyc++;
      end
      if (bus.ACCU != 2'b00) begin
        nadd++;
        seq = {seq[13:0], bus.ACCU};
        if (!active || !(bus.enableSHI && bus.CARGA_SHI) || bus.ACCU == 2'b11) viol = 1'b1;
      end
      if (bus.END) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.lat);
          check("add_cycles", nadd, e.nadd);
          check("accu_seq", int'(seq), int'(e.seq));
          check("accu_legal", int'(viol), 0);
          check("busy_at_end", int'(bus.BUSY), 1);
          if (e.chk_s) check("product", int'(s), int'(e.s));
          if (e.gap != 0) check("end_gap", cyc_g - last_end, e.gap);
        end
        last_end = cyc_g;
        end_cnt++;
        active = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    int         k_tab[8];
    logic [1:0] code_tab[8];
    exp_t       e;
    k_tab    = '{0, 1, 1, 2, 2, 1, 1, 0};
    code_tab = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    total       = 0;
    bad         = 0;
    end_cnt     = 0;
    n_exp       = 0;
    cyc_g       = 0;
    RESET       = 1'b1;
    bus.START   = 1'b0;
    use_dp      = 1'b1;
    forced_ctrl = 3'b000;
    dp_a        = 8'd0;
    dp_b        = 8'd0;
    #1 check("reset_outputs", int'(outs()), 0);
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;

    // Reset at a random point of an idle cycle.
    @(negedge CLOCK);
    #($urandom_range(1, 8)) RESET = 1'b1;
    #1 check("async_reset_outputs", int'(outs()), 0);
    @(negedge CLOCK);
    @(posedge CLOCK);
    #2 RESET = 1'b0;
    repeat (5) @(negedge CLOCK);
    check("no_end_after_reset", end_cnt, 0);

    // A=0: all windows 000, END at cycle 10, product 0.
    run_op(1'b1, 3'b000, 8'd0, 8'd7, mk(10, 0, 0, 1'b1, 0, 0));
    // A=2, B=3: -2M then +M, END at cycle 13, product 6.
    run_op(1'b1, 3'b000, 8'd2, 8'd3, mk(13, 3, 'b10_10_01, 1'b1, 6, 0));

    // Every Booth code forced in all four EVALs.
    for (int c = 0; c < 8; c++) begin
      e = mk(2 + 4 * (2 + k_tab[c]), 4 * k_tab[c], 0, 1'b0, 0, 0);
      for (int j = 0; j < 4 * k_tab[c]; j++) e.seq = {e.seq[13:0], code_tab[c]};
      run_op(1'b0, 3'(c), 8'd0, 8'd0, e);
    end

    // START while BUSY is dropped.
    @(negedge CLOCK);
    use_dp = 1'b1;
    dp_a   = 8'd2;
    dp_b   = 8'd3;
    exp_q.push_back(mk(13, 3, 'b10_10_01, 1'b1, 6, 0));
    n_exp++;
    bus.START = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLOCK);
    bus.START = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    wait_end(n_exp);
    repeat (20) @(negedge CLOCK);
    check("busy_start_ignored", end_cnt, n_exp);

    // START held: back-to-back operations 11 cycles apart.
    @(negedge CLOCK);
    use_dp      = 1'b0;
    forced_ctrl = 3'b000;
    exp_q.push_back(mk(10, 0, 0, 1'b0, 0, 0));
    exp_q.push_back(mk(10, 0, 0, 1'b0, 0, 11));
    n_exp += 2;
    bus.START = 1'b1;
    wait_end(n_exp - 1);
    @(negedge CLOCK);
    @(negedge CLOCK);
    bus.START = 1'b0;
    wait_end(n_exp);

    // Reset while in ADD2 of a +2M iteration.
    repeat (3) @(negedge CLOCK);
    forced_ctrl = 3'b011;
    bus.START   = 1'b1;
    @(posedge CLOCK);
    #1 bus.START = 1'b0;
    repeat (3) @(posedge CLOCK);
    #3 RESET = 1'b1;
    #1 check("reset_in_add2", int'(outs()), 0);
    @(negedge CLOCK);
    @(posedge CLOCK);
    #2 RESET = 1'b0;
    repeat (20) @(negedge CLOCK);
    check("no_end_after_midop_reset", end_cnt, n_exp);

    // Full run after the abort: -1 * 5.
    run_op(1'b1, 3'b000, 8'hFF, 8'd5, mk(11, 1, 'b10, 1'b1, 'hFFFB, 0));

    repeat (5) @(negedge CLOCK);
    check("end_count", end_cnt, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
